// File: rtl/window_perf_select.sv
// Sliding-window best-score selector: each accepted record scores A*T and the
// best account of the last WIN records is emitted once the window is full.
module window_perf_select #(
  parameter int DSIZE = 8,
  parameter int WIN   = 5,
  parameter int MODE  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [DSIZE-1:0]   in_account,
  input  logic [DSIZE-1:0]   in_A,
  input  logic [DSIZE-1:0]   in_T,
  input  logic               in_flush,
  output logic               ready,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [DSIZE-1:0]   out_account,
  output logic [2*DSIZE-1:0] out_perf
);

  localparam int CW = $clog2(WIN + 1);

  logic [DSIZE-1:0]   win_acct [WIN];
  logic [2*DSIZE-1:0] win_perf [WIN];
  logic [DSIZE-1:0]   nxt_acct [WIN];
  logic [2*DSIZE-1:0] nxt_perf [WIN];

  logic [CW-1:0]      count;
  logic [CW-1:0]      count_nxt;
  logic               rst_done;
  logic               accept;
  logic               full_accept;
  logic [2*DSIZE-1:0] new_perf;
  logic [2*DSIZE-1:0] best_perf;
  logic [DSIZE-1:0]   best_acct;

  // rst_done holds ready low for the first cycle after reset release
  assign ready    = rst_done && !(out_valid && !out_ready);
  assign accept   = in_valid && ready;
  assign new_perf = {{DSIZE{1'b0}}, in_A} * {{DSIZE{1'b0}}, in_T};

  always_comb begin
    for (int unsigned i = 0; i < WIN - 1; i++) begin
      nxt_acct[i] = win_acct[i + 1];
      nxt_perf[i] = win_perf[i + 1];
    end
    nxt_acct[WIN-1] = in_account;
    nxt_perf[WIN-1] = new_perf;
  end

  always_comb begin
    count_nxt = count;
    if (in_flush) begin
      count_nxt = accept ? CW'(1) : '0;
    end else if (accept && count != CW'(WIN)) begin
      count_nxt = count + CW'(1);
    end
  end

  assign full_accept = accept && (count_nxt == CW'(WIN));

  // Scan oldest to newest with non-strict compare so the newest tie wins
  always_comb begin
    best_acct = nxt_acct[0];
    best_perf = nxt_perf[0];
    for (int unsigned i = 1; i < WIN; i++) begin
      if ((MODE == 0) ? (nxt_perf[i] <= best_perf) : (nxt_perf[i] >= best_perf)) begin
        best_acct = nxt_acct[i];
        best_perf = nxt_perf[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_done    <= 1'b0;
      count       <= '0;
      out_valid   <= 1'b0;
      out_account <= '0;
      out_perf    <= '0;
      for (int unsigned i = 0; i < WIN; i++) begin
        win_acct[i] <= '0;
        win_perf[i] <= '0;
      end
    end else begin
      rst_done <= 1'b1;
      count    <= count_nxt;
      if (accept) begin
        for (int unsigned i = 0; i < WIN; i++) begin
          win_acct[i] <= nxt_acct[i];
          win_perf[i] <= nxt_perf[i];
        end
      end
      if (full_accept) begin
        out_valid   <= 1'b1;
        out_account <= best_acct;
        out_perf    <= best_perf;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_window_perf_select.sv
// Bench for window_perf_select: MODE=0 and MODE=1 instances share one stimulus
// stream and are compared against a queue-based window model.
module tb_window_perf_select;

  localparam int DSIZE = 8;
  localparam int WIN   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_flush = 1'b0;
  logic               out_ready = 1'b1;
  logic [DSIZE-1:0]   in_account = '0;
  logic [DSIZE-1:0]   in_A = '0;
  logic [DSIZE-1:0]   in_T = '0;
  logic               ready0, ready1, ov0, ov1;
  logic [DSIZE-1:0]   oa0, oa1;
  logic [2*DSIZE-1:0] op0, op1;

  window_perf_select #(.DSIZE(DSIZE), .WIN(WIN), .MODE(0)) u_min (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_account(in_account),
    .in_A(in_A), .in_T(in_T), .in_flush(in_flush), .ready(ready0),
    .out_ready(out_ready), .out_valid(ov0), .out_account(oa0), .out_perf(op0)
  );

  window_perf_select #(.DSIZE(DSIZE), .WIN(WIN), .MODE(1)) u_max (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_account(in_account),
    .in_A(in_A), .in_T(in_T), .in_flush(in_flush), .ready(ready1),
    .out_ready(out_ready), .out_valid(ov1), .out_account(oa1), .out_perf(op1)
  );

  typedef struct {
    int unsigned acct;
    int unsigned perf;
  } rec_t;

  typedef struct {
    int unsigned a, t, acct;
    bit          ev;
    int unsigned amin, pmin, amax, pmax;
  } vec_t;

  rec_t        q[$];
  bit          m_valid, m_rdone;
  int unsigned m_amin, m_pmin, m_amax, m_pmax;
  int unsigned n_pass = 0, n_total = 0;

  task automatic check(string name, longint unsigned act, longint unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_valid = 0; m_rdone = 0;
    m_amin = 0; m_pmin = 0; m_amax = 0; m_pmax = 0;
  endtask

  // Best value first, then the newest record holding that value
  task automatic model_select();
    int unsigned mn, mx;
    bit got_mn, got_mx;
    mn = q[0].perf; mx = q[0].perf;
    foreach (q[i]) begin
      if (q[i].perf < mn) mn = q[i].perf;
      if (q[i].perf > mx) mx = q[i].perf;
    end
    got_mn = 0; got_mx = 0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (!got_mn && q[i].perf == mn) begin m_amin = q[i].acct; got_mn = 1; end
      if (!got_mx && q[i].perf == mx) begin m_amax = q[i].acct; got_mx = 1; end
    end
    m_pmin = mn; m_pmax = mx;
  endtask

  task automatic check_outputs();
    check("out_valid_min", ov0, m_valid);
    check("out_valid_max", ov1, m_valid);
    if (m_valid) begin
      check("out_account_min", oa0, m_amin);
      check("out_perf_min", op0, m_pmin);
      check("out_account_max", oa1, m_amax);
      check("out_perf_max", op1, m_pmax);
    end
  endtask

  // Called at a negedge; drives one cycle and checks outputs at the next negedge
  task automatic step(bit v, int unsigned acct, int unsigned a, int unsigned t,
                      bit fl, bit ordy);
    bit m_ready, acc;
    in_valid = v; in_account = DSIZE'(acct); in_A = DSIZE'(a); in_T = DSIZE'(t);
    in_flush = fl; out_ready = ordy;
    #1;
    m_ready = m_rdone && !(m_valid && !ordy);
    check("ready_min", ready0, m_ready);
    check("ready_max", ready1, m_ready);
    acc = v && m_ready;
    if (fl) q.delete();
    if (acc) begin
      q.push_back('{acct, a * t});
      if (q.size() > WIN) void'(q.pop_front());
    end
    if (acc && q.size() == WIN) begin
      m_valid = 1;
      model_select();
    end else if (m_valid && ordy) begin
      m_valid = 0;
    end
    m_rdone = 1;
    @(negedge clk);
    check_outputs();
  endtask

  // Asynchronous assert in mid low phase, release on a negedge
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_out_valid", ov0 | ov1, 0);
    check("rst_out_account", {oa0, oa1}, 0);
    check("rst_out_perf", {op0, op1}, 0);
    check("rst_ready", ready0 | ready1, 0);
    in_valid = 0; in_flush = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{2,   3,   10, 0, 0,  0, 0,  0};
    tbl[1] = '{1,   5,   11, 0, 0,  0, 0,  0};
    tbl[2] = '{4,   4,   12, 0, 0,  0, 0,  0};
    tbl[3] = '{3,   3,   13, 0, 0,  0, 0,  0};
    tbl[4] = '{7,   1,   14, 1, 11, 5, 12, 16};
    tbl[5] = '{5,   1,   15, 1, 15, 5, 12, 16};
    tbl[6] = '{255, 255, 20, 1, 15, 5, 20, 65025};

    // Reset, then a record offered in the first cycle after release is refused
    do_reset();
    step(1, 99, 1, 1, 0, 1);

    foreach (tbl[i]) begin
      step(1, tbl[i].acct, tbl[i].a, tbl[i].t, 0, 1);
      check("tbl_valid", ov0, tbl[i].ev);
      if (tbl[i].ev) begin
        check("tbl_acct_min", oa0, tbl[i].amin);
        check("tbl_perf_min", op0, tbl[i].pmin);
        check("tbl_acct_max", oa1, tbl[i].amax);
        check("tbl_perf_max", op1, tbl[i].pmax);
      end
    end

    // Back-pressure: output held, no record taken for 10 cycles
    do_reset();
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, tbl[i].acct, tbl[i].a, tbl[i].t, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step(1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 0, 0);
      check("bp_ready", ready0, 0);
      check("bp_hold_acct", oa0, 11);
    end
    step(1, 15, 5, 1, 0, 1);
    check("bp_resume_acct", oa0, 15);
    check("bp_resume_perf", op0, 5);
    step(0, 0, 0, 0, 0, 1);
    check("bp_drain_valid", ov0, 0);

    // Flush alone, then a fresh five-record window
    step(0, 0, 0, 0, 1, 1);
    step(1, 30, 9, 9, 0, 1);
    step(1, 31, 8, 9, 0, 1);
    step(1, 32, 10, 10, 0, 1);
    step(1, 33, 9, 8, 0, 1);
    check("flush_fill_valid", ov0, 0);
    step(1, 34, 12, 12, 0, 1);
    check("flush_acct_min", oa0, 33);
    check("flush_perf_min", op0, 72);
    check("flush_acct_max", oa1, 34);
    check("flush_perf_max", op1, 144);

    // Flush with accept: that record is entry 1
    step(1, 40, 2, 2, 1, 1);
    step(1, 41, 3, 3, 0, 1);
    step(1, 42, 0, 7, 0, 1);
    step(1, 43, 6, 6, 0, 1);
    check("flushacc_fill_valid", ov0, 0);
    step(1, 44, 5, 5, 0, 1);
    check("flushacc_acct_min", oa0, 42);
    check("flushacc_perf_min", op0, 0);
    check("flushacc_acct_max", oa1, 43);
    check("flushacc_perf_max", op1, 36);

    // Reset while out_valid=1, then a full refill is required
    check("pre_rst_valid", ov0, 1);
    do_reset();
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 50 + i, i + 1, 3, 0, 1);
    check("refill_valid", ov0, 0);
    step(1, 54, 1, 1, 0, 1);
    check("refill_acct_min", oa0, 54);
    check("refill_perf_min", op0, 1);

    // Random traffic against the window model
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 255),
           ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255),
           ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 255),
           $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/window_perf_select.md
Name: window_perf_select

Overview:
- Streaming selector: each accepted record (account ID, A, T) gets a performance score A*T and enters a sliding window of the last WIN records.
- Once the window is full, every accepted record produces one output: the account ID with the best score in the current window (min or max, set by MODE).
- Parametrised single-clock successor of the fixed 5-deep minimum selector used in the account-ranking lab flow. Adds configurable width, depth and mode, plus flush and downstream back-pressure.

Parameters:
- DSIZE, 8, width of account/A/T.
- WIN, 5, window depth in records (2..16).
- MODE, 0, 0 = select minimum score, 1 = select maximum score.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  record present; accepted only when ready=1.
- in_account  input  DSIZE  account ID of record.
- in_A  input  DSIZE  unsigned operand A.
- in_T  input  DSIZE  unsigned operand T.
- in_flush  input  1  clear window contents (count to 0).
- ready  output  1  block can accept a record this cycle.
- out_ready  input  1  downstream accepts output this cycle.
- out_valid  output  1  out_account/out_perf valid.
- out_account  output  DSIZE  selected account ID.
- out_perf  output  2*DSIZE  score of selected account.

Behaviour:
- Reset (async assert, sync release): window count=0, all window entries=0, out_valid=0, out_account=0, out_perf=0. ready=0 while rst=1 and in the first cycle after release. Reset mid-stream discards the window and any held output.
- ready = !(out_valid && !out_ready), and 0 in the reset conditions above.
- Accept = in_valid && ready. On accept, perf = in_A*in_T (unsigned, 2*DSIZE bits, no truncation).
  - Record shifts into the newest window slot; oldest slot drops.
  - count increments, saturating at WIN.
- Output, registered with latency 1: when an accept makes the window full (count after the update = WIN), then on the next edge out_valid=1, out_account and out_perf = best entry of the updated window (includes the new record).
  - MODE=0: smallest perf. MODE=1: largest perf.
  - Tie: newest entry wins.
- Output handshake:
  - out_valid && out_ready with no new full accept -> out_valid clears next cycle.
  - out_valid && !out_ready -> outputs hold stable and ready=0, so no record is lost or overwritten.
  - Back-to-back: an accept in the same cycle as out_ready=1 reloads the output.
- Fill phase: the first WIN-1 accepts after reset or flush produce no output.
- in_flush:
  - count=0 next cycle; entries need not be cleared, but are never used until refilled.
  - A pending out_valid is unaffected.
  - Flush with accept in the same cycle: window cleared, then the new record loaded as the first entry (count=1).
- Operands of 0 are legal (perf 0). The max score is (2^DSIZE-1)^2.
- Record rate: one per cycle while out_ready is held high.

Test Plan:
- Basic min, DSIZE=8, WIN=5, MODE=0, out_ready=1.
  - Stimulus (A,T,acct): (2,3,10),(1,5,11),(4,4,12),(3,3,13),(7,1,14).
  - No out_valid for the first 4 records; after the 5th, out_valid=1, out_account=11, out_perf=5.
- Tie plus slide: continue with (5,1,15).
  - Window scores 5,16,9,7,5 -> out_account=15, out_perf=5 (newest tie wins).
- MODE=1 on the same first 5 records -> out_account=12, out_perf=16.
  - Then add (255,255,20) -> out_account=20, out_perf=65025.
- Back-pressure: hold out_ready=0 after the first output.
  - ready=0 and out_account=11 stable for 10 cycles; in_valid offered meanwhile is not accepted.
  - Raise out_ready: the next record is accepted and its output is correct.
- Flush: after a full window, assert in_flush alone, then send 4 records.
  - No output until the 5th post-flush record, which selects only among post-flush entries.
  - Flush plus valid in one cycle -> that record counts as entry 1.
- Reset mid-stream: assert rst with out_valid=1.
  - All outputs 0 immediately; ready=0 one cycle after release.
  - A full refill of 5 records is needed before the next output.
